// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead (first-word-fall-through) read data.
// The head entry is presented on rdata combinationally from storage and can be
// popped in the same cycle it is inspected.
// Optional macro SYNC_FIFO_CHECK_EN compiles in simulation-only overflow/underflow
// messages; the default build (macro undefined) is purely synthesizable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  output logic             full,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic pop_ok;
  logic push_ok;

  // Status flags and head data come straight from the occupancy count.
  always_comb begin
    valid = (count_q != '0);
    full  = (count_q == CNT_FULL);
    rdata = valid ? mem_q[rptr_q] : '0;
  end

  // Accept decisions use the pre-edge state; a full FIFO still takes a push
  // when the head is being popped in the same cycle.
  always_comb begin
    pop_ok  = pop & valid;
    push_ok = push & (~full | pop_ok);
  end

  // Next-state for pointers and count; pointers wrap at DEPTH-1, which also
  // keeps them pinned at 0 when DEPTH is 1.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    end
    if (pop_ok) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers; reset discards all queued entries at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; valid gates rdata until it is written.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

`ifdef SYNC_FIFO_CHECK_EN
  // Simulation-only usage checks; they observe and never drive the datapath.
  always @(posedge clock) begin
    if (reset) begin
      if (push && full && !pop_ok) begin
        $display("sync_fifo overflow error in %m: push while full, wdata=%h dropped", wdata);
      end
      if (pop && !valid) begin
        $display("sync_fifo underflow error in %m: pop while empty ignored");
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (WIDTH=8, DEPTH=4) with hand-computed expectations.
// Inputs change #1 after a rising edge; outputs are sampled at that same point,
// i.e. they reflect the state produced by the edge just taken.
module tb_sync_fifo;

  logic       clock;
  logic       reset;
  logic       full;
  logic       push;
  logic [7:0] wdata;
  logic       pop;
  logic [7:0] rdata;
  logic       valid;

  int n_checks = 0;
  int n_fails  = 0;

  sync_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .full  (full),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .valid (valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic v, input logic f, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".full"},  32'(full),  32'(f));
    chk({tag, ".rdata"}, 32'(rdata), 32'(d));
  endtask

  // One clock cycle with the given request inputs, then inputs return to idle.
  task automatic step(input logic p, input logic [7:0] d, input logic q);
    push  = p;
    wdata = d;
    pop   = q;
    @(posedge clock);
    #1;
    push  = 1'b0;
    wdata = 8'h00;
    pop   = 1'b0;
  endtask

  task automatic fill_11_44();
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
  endtask

  // Check the head value, then pop it.
  task automatic pop_expect(input string tag, input logic [7:0] d);
    chk({tag, ".head_valid"}, 32'(valid), 32'h1);
    chk({tag, ".head_rdata"}, 32'(rdata), 32'(d));
    step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    push  = 1'b0;
    wdata = 8'h00;
    pop   = 1'b0;

    // 1. reset, then idle
    @(posedge clock);
    @(posedge clock);
    #1;
    chk_state("in_reset", 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    chk_state("idle", 1'b0, 1'b0, 8'h00);

    // 2. fill and drain
    step(1'b1, 8'h11, 1'b0);
    chk_state("first_push", 1'b1, 1'b0, 8'h11);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    chk_state("three_in", 1'b1, 1'b0, 8'h11);
    step(1'b1, 8'h44, 1'b0);
    chk_state("fourth_push", 1'b1, 1'b1, 8'h11);
    pop_expect("drain0", 8'h11);
    chk("drain0.full_cleared", 32'(full), 32'h0);
    pop_expect("drain1", 8'h22);
    pop_expect("drain2", 8'h33);
    pop_expect("drain3", 8'h44);
    chk_state("drained", 1'b0, 1'b0, 8'h00);

    // 3. overflow: push while full without pop is dropped
    fill_11_44();
    step(1'b1, 8'h55, 1'b0);
    chk_state("overflow", 1'b1, 1'b1, 8'h11);
    pop_expect("ovf0", 8'h11);
    pop_expect("ovf1", 8'h22);
    pop_expect("ovf2", 8'h33);
    pop_expect("ovf3", 8'h44);
    chk_state("ovf_drained", 1'b0, 1'b0, 8'h00);

    // 4a. push and pop together while full
    fill_11_44();
    chk_state("full_again", 1'b1, 1'b1, 8'h11);
    step(1'b1, 8'h66, 1'b1);
    chk_state("full_pushpop", 1'b1, 1'b1, 8'h22);
    pop_expect("pp0", 8'h22);
    pop_expect("pp1", 8'h33);
    pop_expect("pp2", 8'h44);
    pop_expect("pp3", 8'h66);
    chk_state("pp_drained", 1'b0, 1'b0, 8'h00);

    // 4b. push and pop together while empty: push wins, pop ignored
    step(1'b1, 8'h77, 1'b1);
    chk_state("empty_pushpop", 1'b1, 1'b0, 8'h77);
    pop_expect("ep0", 8'h77);
    chk_state("ep_drained", 1'b0, 1'b0, 8'h00);

    // pop while empty is ignored, no underflow
    step(1'b0, 8'h00, 1'b1);
    chk_state("underflow", 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'h3C, 1'b0);
    chk_state("after_underflow", 1'b1, 1'b0, 8'h3C);
    pop_expect("au0", 8'h3C);
    chk_state("au_drained", 1'b0, 1'b0, 8'h00);

    // 5. wrap-around: 10 rounds of push-2/pop-2 with values 0x00..0x13
    for (int r = 0; r < 10; r++) begin
      step(1'b1, 8'(2 * r), 1'b0);
      step(1'b1, 8'(2 * r + 1), 1'b0);
      chk("wrap.not_full", 32'(full), 32'h0);
      pop_expect("wrap_a", 8'(2 * r));
      pop_expect("wrap_b", 8'(2 * r + 1));
      chk("wrap.empty", 32'(valid), 32'h0);
    end

    // 6. asynchronous reset with three entries queued
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    step(1'b1, 8'hCC, 1'b0);
    chk_state("pre_async", 1'b1, 1'b0, 8'hAA);
    #2;
    reset = 1'b0;
    #1;
    chk_state("async_reset", 1'b0, 1'b0, 8'h00);
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(1'b1, 8'hA5, 1'b0);
    chk_state("post_reset_push", 1'b1, 1'b0, 8'hA5);
    pop_expect("pr0", 8'hA5);
    chk_state("pr_drained", 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
